// File: rtl/dsp_dot_sequencer.sv
// Upstream sequencer for a DSP48A1 slice that accumulates a dot product.
// It accepts operand pairs over valid/ready and drives the slice A, B and
// OPMODE inputs. After the last pair it waits for the slice pipeline to
// drain, then captures P and CARRYOUT and holds them on a valid/ready output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the first pair of a vector
// ACCUM | mid-vector, accepting further pairs (bubbles allowed)
// DRAIN | last pair taken, counting down the slice pipeline latency
// HOLD  | result captured, out_valid high until the consumer takes it
module dsp_dot_sequencer #(
    parameter int DW      = 18,
    parameter int PW      = 48,
    parameter int LEN_W   = 8,
    parameter int OP_SKEW = 1,
    parameter int RES_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_data,
    output logic             out_carry,
    output logic [LEN_W-1:0] out_len,
    output logic [DW-1:0]    dsp_a,
    output logic [DW-1:0]    dsp_b,
    output logic [7:0]       dsp_opmode,
    input  logic [PW-1:0]    dsp_p,
    input  logic             dsp_carryout,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // X=M, Z=0 starts a fresh sum; X=M, Z=P keeps adding onto P.
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    localparam int CNT_W = (RES_LAT < 2) ? 1 : $clog2(RES_LAT + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(RES_LAT);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             first_accept;
    logic             capture;
    logic [CNT_W-1:0] drain_cnt;
    logic [LEN_W-1:0] len_cnt;
    logic [7:0]       opm_pipe [0:OP_SKEW];

    assign accept       = in_valid & in_ready;
    assign first_accept = accept & (state == S_IDLE);
    assign capture      = (state == S_DRAIN) && (drain_cnt == '0);
    assign busy         = (state != S_IDLE);
    assign dsp_opmode   = opm_pipe[OP_SKEW];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state; in_ready and out_valid depend on state only
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE, S_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_last ? S_DRAIN : S_ACCUM;
            end
            S_DRAIN: begin
                if (drain_cnt == '0) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands reach the slice only on accepts; zero elsewhere so M=0 adds nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            dsp_a <= '0;
            dsp_b <= '0;
        end else if (accept) begin
            dsp_a <= in_a;
            dsp_b <= in_b;
        end else begin
            dsp_a <= '0;
            dsp_b <= '0;
        end
    end

    // OPMODE code per sample, delayed to line up with the slice's M stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= OP_SKEW; i++) opm_pipe[i] <= OPM_ACC;
        end else begin
            opm_pipe[0] <= first_accept ? OPM_FIRST : OPM_ACC;
            for (int i = 1; i <= OP_SKEW; i++) opm_pipe[i] <= opm_pipe[i-1];
        end
    end

    // Drain timer: loaded on the last accept, capture fires when it hits zero
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (accept && in_last) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Pair counter for the vector in flight, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            len_cnt <= '0;
        end else if (first_accept) begin
            len_cnt <= LEN_W'(1);
        end else if (accept && (len_cnt != '1)) begin
            len_cnt <= len_cnt + LEN_W'(1);
        end
    end

    // Result registers only change on capture, so they hold across vectors
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_carry <= 1'b0;
            out_len   <= '0;
        end else if (capture) begin
            out_data  <= dsp_p;
            out_carry <= dsp_carryout;
            out_len   <= len_cnt;
        end
    end

endmodule
